// File: rtl/csr_trap_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : csr_trap_unit_if
//  Purpose  : Bundles the CSR access port, the trap/mret commit port, the
//             interrupt lines and the feedback to the exception unit.
//  Revision : 1.0  initial release
// ============================================================================
interface csr_trap_unit_if;
    // Zicsr access from execute
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    // Trap / return commit
    logic        exception;
    logic        interrupt;
    logic [31:0] exception_pc;
    logic [31:0] exception_cause;
    logic        mret;
    logic [31:0] mepc_out;
    // Retirement and interrupt lines
    logic        instr_retire;
    logic        ext_irq;
    logic        timer_irq;
    logic        irq_pending;
    // Feedback to exception unit
    logic        interrupt_en;
    logic [1:0]  mtvec_mode;
    logic [31:0] mtvec_base;

    modport slave (
        input  csr_op, csr_addr, csr_wdata,
        input  exception, interrupt, exception_pc, exception_cause, mret,
        input  instr_retire, ext_irq, timer_irq,
        output csr_rdata, csr_illegal, mepc_out, irq_pending,
        output interrupt_en, mtvec_mode, mtvec_base
    );

    modport master (
        output csr_op, csr_addr, csr_wdata,
        output exception, interrupt, exception_pc, exception_cause, mret,
        output instr_retire, ext_irq, timer_irq,
        input  csr_rdata, csr_illegal, mepc_out, irq_pending,
        input  interrupt_en, mtvec_mode, mtvec_base
    );
endinterface
`default_nettype wire

// File: rtl/csr_trap_unit.sv
`default_nettype none
// ============================================================================
//  Module   : csr_trap_unit
//  Purpose  : Machine-mode trap CSR file: trap capture, mret, Zicsr access,
//             mcycle/minstret counters and interrupt-pending generation.
//  Revision : 1.0  initial release
// ============================================================================
module csr_trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    csr_trap_unit_if.slave  bus
);

    localparam logic [11:0] c_MSTATUS  = 12'h300;
    localparam logic [11:0] c_MIE      = 12'h304;
    localparam logic [11:0] c_MTVEC    = 12'h305;
    localparam logic [11:0] c_MSCRATCH = 12'h340;
    localparam logic [11:0] c_MEPC     = 12'h341;
    localparam logic [11:0] c_MCAUSE   = 12'h342;
    localparam logic [11:0] c_MIP      = 12'h344;
    localparam logic [11:0] c_MCYCLE   = 12'hB00;
    localparam logic [11:0] c_MCYCLEH  = 12'hB80;
    localparam logic [11:0] c_MINSTRET = 12'hB02;
    localparam logic [11:0] c_MINSTRH  = 12'hB82;
    localparam logic [11:0] c_MHARTID  = 12'hF14;

    localparam logic [1:0]  c_OP_NONE  = 2'b00;
    localparam logic [1:0]  c_OP_RW    = 2'b01;
    localparam logic [1:0]  c_OP_RS    = 2'b10;

    // Architectural state
    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic        r_mie_mtie;
    logic        r_mie_meie;
    logic        r_mip_mtip;
    logic        r_mip_meip;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:2] r_mepc;
    logic [31:0] r_mcause;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    logic [31:0] w_rdata;
    logic        w_impl;
    logic        w_ro;
    logic        w_wr_real;
    logic        w_illegal;
    logic        w_wen;
    logic [31:0] w_new;
    logic        w_unused;

    // Only the low 31 cause bits are architecturally captured.
    assign w_unused = bus.exception_cause[31];

    // Read mux: decodes the address and flags read-only/unimplemented targets
    always_comb begin
        w_rdata = 32'd0;
        w_impl  = 1'b1;
        w_ro    = 1'b0;
        case (bus.csr_addr)
            c_MSTATUS:  w_rdata = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
            c_MIE:      w_rdata = {20'd0, r_mie_meie, 3'd0, r_mie_mtie, 7'd0};
            c_MTVEC:    w_rdata = r_mtvec;
            c_MSCRATCH: w_rdata = r_mscratch;
            c_MEPC:     w_rdata = {r_mepc, 2'b00};
            c_MCAUSE:   w_rdata = r_mcause;
            c_MIP: begin
                w_rdata = {20'd0, r_mip_meip, 3'd0, r_mip_mtip, 7'd0};
                w_ro    = 1'b1;
            end
            c_MCYCLE:   w_rdata = r_mcycle[31:0];
            c_MCYCLEH:  w_rdata = r_mcycle[63:32];
            c_MINSTRET: w_rdata = r_minstret[31:0];
            c_MINSTRH:  w_rdata = r_minstret[63:32];
            c_MHARTID: begin
                w_rdata = HART_ID;
                w_ro    = 1'b1;
            end
            default:    w_impl  = 1'b0;
        endcase
    end

    // RS/RC with a zero mask is a pure read and never has write side effects.
    assign w_wr_real = (bus.csr_op == c_OP_RW) ||
                       ((bus.csr_op != c_OP_NONE) && (bus.csr_wdata != 32'd0));
    assign w_illegal = (bus.csr_op != c_OP_NONE) && (!w_impl || (w_ro && w_wr_real));
    // A trap in the same cycle flushes the instruction issuing the write.
    assign w_wen     = (bus.csr_op != c_OP_NONE) && w_wr_real && !w_illegal && !bus.exception;

    // Write-value computation for RW / RS / RC
    always_comb begin
        w_new = bus.csr_wdata;
        if (bus.csr_op == c_OP_RS) begin
            w_new = w_rdata | bus.csr_wdata;
        end else if (bus.csr_op != c_OP_RW) begin
            w_new = w_rdata & ~bus.csr_wdata;
        end
    end

    // mstatus: trap beats mret, mret beats a software write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
        end else if (bus.exception) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (bus.mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_wen && (bus.csr_addr == c_MSTATUS)) begin
            r_mstatus_mie  <= w_new[3];
            r_mstatus_mpie <= w_new[7];
        end
    end

    // mepc/mcause: trap capture has priority over software writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mepc   <= 30'd0;
            r_mcause <= 32'd0;
        end else if (bus.exception) begin
            r_mepc   <= bus.exception_pc[31:2];
            r_mcause <= {bus.interrupt, bus.exception_cause[30:0]};
        end else if (w_wen) begin
            if (bus.csr_addr == c_MEPC) begin
                r_mepc <= w_new[31:2];
            end
            if (bus.csr_addr == c_MCAUSE) begin
                r_mcause <= w_new;
            end
        end
    end

    // Plain software-written CSRs: mie, mtvec (WARL mode), mscratch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie_mtie <= 1'b0;
            r_mie_meie <= 1'b0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= 32'd0;
        end else if (w_wen) begin
            case (bus.csr_addr)
                c_MIE: begin
                    r_mie_mtie <= w_new[7];
                    r_mie_meie <= w_new[11];
                end
                // Modes 2 and 3 are reserved: keep the previous mode.
                c_MTVEC:    r_mtvec <= {w_new[31:2], w_new[1] ? r_mtvec[1:0] : w_new[1:0]};
                c_MSCRATCH: r_mscratch <= w_new;
                default: ;
            endcase
        end
    end

    // Interrupt lines are registered into mip every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mip_mtip <= 1'b0;
            r_mip_meip <= 1'b0;
        end else begin
            r_mip_mtip <= bus.timer_irq;
            r_mip_meip <= bus.ext_irq;
        end
    end

    // mcycle: free-running unless software loads one half this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcycle <= 64'd0;
        end else if (w_wen && (bus.csr_addr == c_MCYCLE)) begin
            r_mcycle[31:0] <= w_new;
        end else if (w_wen && (bus.csr_addr == c_MCYCLEH)) begin
            r_mcycle[63:32] <= w_new;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end

    // minstret: counts retirements that are not being trapped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_minstret <= 64'd0;
        end else if (w_wen && (bus.csr_addr == c_MINSTRET)) begin
            r_minstret[31:0] <= w_new;
        end else if (w_wen && (bus.csr_addr == c_MINSTRH)) begin
            r_minstret[63:32] <= w_new;
        end else if (bus.instr_retire && !bus.exception) begin
            r_minstret <= r_minstret + 64'd1;
        end
    end

    assign bus.csr_rdata    = w_rdata;
    assign bus.csr_illegal  = w_illegal;
    assign bus.mepc_out     = {r_mepc, 2'b00};
    assign bus.interrupt_en = r_mstatus_mie;
    assign bus.irq_pending  = r_mstatus_mie &
                              ((r_mie_mtie & r_mip_mtip) | (r_mie_meie & r_mip_meip));
    assign bus.mtvec_mode   = r_mtvec[1:0];
    assign bus.mtvec_base   = {r_mtvec[31:2], 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_trap_unit
//  Purpose  : Self-checking bench for csr_trap_unit: directed scenarios plus
//             randomized traffic against a behavioural CSR model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csr_trap_unit;

    localparam logic [31:0] MTVEC_RESET = 32'h0000_1001;
    localparam logic [31:0] HART_ID     = 32'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_trap_unit_if bus ();

    csr_trap_unit #(.MTVEC_RESET(MTVEC_RESET), .HART_ID(HART_ID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Behavioural model: architectural view of every CSR
    bit          m_ie, m_pie;
    logic [31:0] m_mie, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ret;

    function automatic bit m_impl(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14};
    endfunction

    function automatic bit m_ro(input logic [11:0] a);
        return (a == 12'h344) || (a == 12'hF14);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 + (32'(m_ie) * 8) + (32'(m_pie) * 128);
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ret[31:0];
            12'hB82: return m_ret[63:32];
            12'hF14: return HART_ID;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_real_write();
        return (bus.csr_op == 2'd1) || (bus.csr_op != 2'd0 && bus.csr_wdata != 32'd0);
    endfunction

    function automatic bit m_illegal();
        return (bus.csr_op != 2'd0) &&
               (!m_impl(bus.csr_addr) || (m_ro(bus.csr_addr) && m_real_write()));
    endfunction

    // Advance the model by one rising edge using the inputs present at that edge
    task automatic model_step();
        logic [31:0] old, nv;
        bit do_wr;
        logic [11:0] a;
        logic [63:0] cyc_n, ret_n;
        if (rst) begin
            m_ie = 0; m_pie = 0; m_mie = 0; m_mip = 0; m_mscratch = 0;
            m_mepc = 0; m_mcause = 0; m_mtvec = MTVEC_RESET; m_cyc = 0; m_ret = 0;
            return;
        end
        a     = bus.csr_addr;
        old   = m_read(a);
        case (bus.csr_op)
            2'd1:    nv = bus.csr_wdata;
            2'd2:    nv = old | bus.csr_wdata;
            default: nv = old & ~bus.csr_wdata;
        endcase
        do_wr = (bus.csr_op != 2'd0) && m_real_write() && !m_illegal() && !bus.exception;
        cyc_n = m_cyc + 64'd1;
        ret_n = (bus.instr_retire && !bus.exception) ? m_ret + 64'd1 : m_ret;
        if (do_wr) begin
            if (a == 12'hB00) cyc_n = {m_cyc[63:32], nv};
            if (a == 12'hB80) cyc_n = {nv, m_cyc[31:0]};
            if (a == 12'hB02) ret_n = {m_ret[63:32], nv};
            if (a == 12'hB82) ret_n = {nv, m_ret[31:0]};
        end
        m_cyc = cyc_n;
        m_ret = ret_n;
        if (bus.exception) begin
            m_mepc   = bus.exception_pc & ~32'd3;
            m_mcause = {bus.interrupt, bus.exception_cause[30:0]};
            m_pie    = m_ie;
            m_ie     = 0;
        end else begin
            if (bus.mret) begin
                m_ie  = m_pie;
                m_pie = 1;
            end else if (do_wr && a == 12'h300) begin
                m_ie  = nv[3];
                m_pie = nv[7];
            end
            if (do_wr) begin
                case (a)
                    12'h304: m_mie = nv & 32'h0000_0880;
                    12'h305: m_mtvec = (nv[1:0] >= 2'd2) ? {nv[31:2], m_mtvec[1:0]} : nv;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & ~32'd3;
                    12'h342: m_mcause = nv;
                    default: ;
                endcase
            end
        end
        m_mip = (bus.timer_irq ? 32'h80 : 32'h0) | (bus.ext_irq ? 32'h800 : 32'h0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata",        bus.csr_rdata, m_read(bus.csr_addr));
            chk("illegal",      32'(bus.csr_illegal), 32'(m_illegal()));
            chk("mepc_out",     bus.mepc_out, m_mepc);
            chk("interrupt_en", 32'(bus.interrupt_en), 32'(m_ie));
            chk("irq_pending",  32'(bus.irq_pending), 32'(m_ie && ((m_mie & m_mip) != 0)));
            chk("mtvec_mode",   32'(bus.mtvec_mode), 32'(m_mtvec[1:0]));
            chk("mtvec_base",   bus.mtvec_base, m_mtvec & ~32'd3);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        bus.csr_op = 2'd0; bus.csr_addr = 12'h000; bus.csr_wdata = 32'd0;
        bus.exception = 1'b0; bus.interrupt = 1'b0; bus.exception_pc = 32'd0;
        bus.exception_cause = 32'd0; bus.mret = 1'b0; bus.instr_retire = 1'b0;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        idle();
        bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = d;
        tick();
        idle();
    endtask

    task automatic peek(input string nm, input logic [11:0] a, input logic [31:0] exp);
        bus.csr_op = 2'd0; bus.csr_addr = a;
        #1;
        chk(nm, bus.csr_rdata, exp);
    endtask

    logic [11:0] addr_tbl [14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14,
                                   12'h301, 12'h7C0};

    initial begin
        idle();
        bus.ext_irq = 1'b0; bus.timer_irq = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        peek("rst_mstatus", 12'h300, 32'h0000_1800);
        peek("rst_mtvec",   12'h305, 32'h0000_1001);
        peek("rst_mcycle",  12'hB00, 32'd0);
        chk("rst_ie", 32'(bus.interrupt_en), 32'd0);

        // Enable MIE, then trap
        csr(2'd1, 12'h300, 32'h8);
        chk("mie_set", 32'(bus.interrupt_en), 32'd1);
        bus.exception = 1'b1; bus.exception_pc = 32'h104; bus.exception_cause = 32'd2;
        tick(); idle();
        peek("trap_mepc",    12'h341, 32'h104);
        peek("trap_mcause",  12'h342, 32'd2);
        peek("trap_mstatus", 12'h300, 32'h0000_1880);

        // mret restores MIE; then mret+trap together, trap wins
        bus.mret = 1'b1; tick(); idle();
        peek("mret_mstatus", 12'h300, 32'h0000_1888);
        bus.mret = 1'b1; bus.exception = 1'b1; bus.exception_pc = 32'h200; tick(); idle();
        chk("mret_vs_trap", 32'(bus.interrupt_en), 32'd0);

        // External interrupt pending path
        csr(2'd1, 12'h304, 32'h800);
        csr(2'd1, 12'h300, 32'h8);
        bus.ext_irq = 1'b1; #1;
        chk("irq_not_yet", 32'(bus.irq_pending), 32'd0);
        tick();
        chk("irq_pending", 32'(bus.irq_pending), 32'd1);
        csr(2'd3, 12'h304, 32'h800);
        chk("irq_cleared", 32'(bus.irq_pending), 32'd0);
        bus.ext_irq = 1'b0;

        // mtvec WARL and read-only violation
        csr(2'd1, 12'h305, 32'h8000_0003);
        chk("mtvec_base", bus.mtvec_base, 32'h8000_0000);
        chk("mtvec_mode", 32'(bus.mtvec_mode), 32'd1);
        bus.csr_op = 2'd1; bus.csr_addr = 12'hF14; bus.csr_wdata = 32'd1; #1;
        chk("hartid_illegal", 32'(bus.csr_illegal), 32'd1);
        chk("hartid_read", bus.csr_rdata, 32'd3);
        tick(); idle();

        // mcycle carry into mcycleh
        csr(2'd1, 12'hB80, 32'd0);
        bus.csr_op = 2'd1; bus.csr_addr = 12'hB00; bus.csr_wdata = 32'hFFFF_FFFF;
        tick(); idle();
        peek("mcycle_loaded", 12'hB00, 32'hFFFF_FFFF);
        tick();
        peek("mcycleh_carry", 12'hB80, 32'd1);
        peek("mcycle_wrap",   12'hB00, 32'd0);

        // Write flushed by a same-cycle trap
        csr(2'd1, 12'h340, 32'h55);
        bus.csr_op = 2'd1; bus.csr_addr = 12'h340; bus.csr_wdata = 32'hAA;
        bus.exception = 1'b1; bus.exception_pc = 32'h300;
        tick(); idle();
        peek("mscratch_kept", 12'h340, 32'h55);

        // Randomized traffic checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            rst                 = ($urandom_range(0, 199) == 0);
            bus.csr_op          = 2'($urandom_range(0, 3));
            bus.csr_addr        = addr_tbl[$urandom_range(0, 13)];
            bus.csr_wdata       = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            bus.exception       = ($urandom_range(0, 7) == 0);
            bus.interrupt       = 1'($urandom_range(0, 1));
            bus.exception_pc    = $urandom;
            bus.exception_cause = $urandom;
            bus.mret            = ($urandom_range(0, 7) == 0);
            bus.instr_retire    = 1'($urandom_range(0, 1));
            bus.ext_irq         = 1'($urandom_range(0, 1));
            bus.timer_irq       = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
